// File: rtl/shift_seq_pkg.sv
// Shared constants for the shift-register sequencer: register mode codes,
// transfer op codes and the sequencer state encoding.
package shift_seq_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHL  = 2'b01;
   localparam logic [1:0] MODE_SHR  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   localparam logic [1:0] OP_TX_MSB = 2'b00;
   localparam logic [1:0] OP_TX_LSB = 2'b01;
   localparam logic [1:0] OP_RX_MSB = 2'b10;
   localparam logic [1:0] OP_RX_LSB = 2'b11;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   // Op code bit 1 selects receive, bit 0 selects LSB-first.
   function automatic logic is_rx(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic is_lsb(input logic [1:0] op);
      return op[0];
   endfunction

endpackage

// File: rtl/shift_reg_seq.sv
// Sequencer that walks an external universal shift register through
// load/shift/hold to serialise (TX) or deserialise (RX) one word per command.
module shift_reg_seq
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             abort,
   input  logic             ser_in,
   output logic             ser_out,
   output logic             ser_valid,
   output logic [WIDTH-1:0] rx_data,
   output logic             done,
   output logic             busy,
   output logic [1:0]       sr_mode,
   output logic [WIDTH-1:0] sr_data_in,
   output logic             sr_shift_left,
   output logic             sr_shift_right,
   input  logic [WIDTH-1:0] sr_data_out
);

   state_t             state, state_nxt;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   data_q;
   logic [WIDTH-1:0]   rx_q;
   logic [CNT_W-1:0]   cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         op_q   <= '0;
         data_q <= '0;
         cnt    <= '0;
         rx_q   <= '0;
      end else begin
         state <= state_nxt;
         if (cmd_valid && cmd_ready) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
         end
         if (state == LOAD)
            cnt <= CNT_W'(WIDTH);
         else if (state == SHIFT && cnt != '0)
            cnt <= cnt - 1'b1;
         if (state == DONE && is_rx(op_q))
            rx_q <= sr_data_out;
      end
   end

   always_comb begin
      state_nxt      = state;
      cmd_ready      = 1'b0;
      sr_mode        = MODE_HOLD;
      sr_data_in     = '0;
      sr_shift_left  = 1'b0;
      sr_shift_right = 1'b0;
      ser_out        = 1'b0;
      ser_valid      = 1'b0;
      done           = 1'b0;
      rx_data        = rx_q;
      busy           = (state != IDLE);

      case (state)
         IDLE: begin
            // Reset holds state at IDLE, so gate ready with rst to keep it low.
            cmd_ready = rst;
            if (cmd_valid && rst)
               state_nxt = LOAD;
         end
         LOAD: begin
            sr_mode = MODE_LOAD;
            if (!is_rx(op_q))
               sr_data_in = data_q;
            state_nxt = abort ? IDLE : SHIFT;
         end
         SHIFT: begin
            sr_mode   = is_lsb(op_q) ? MODE_SHR : MODE_SHL;
            ser_valid = 1'b1;
            if (!is_rx(op_q))
               ser_out = is_lsb(op_q) ? sr_data_out[0] : sr_data_out[WIDTH-1];
            else if (is_lsb(op_q))
               sr_shift_right = ser_in;
            else
               sr_shift_left = ser_in;
            if (abort)
               state_nxt = IDLE;
            else if (cnt == CNT_W'(1))
               state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (is_rx(op_q))
               rx_data = sr_data_out;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_shift_reg_seq.sv
// Bench for shift_reg_seq with a behavioural universal shift register and a
// transfer-level reference model checked every cycle, plus directed scenarios.
module tb_shift_reg_seq;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         cmd_valid = 1'b0;
   logic [1:0]   cmd_op = 2'b00;
   logic [W-1:0] cmd_data = '0;
   logic         abort = 1'b0;
   logic         ser_in = 1'b0;
   logic         cmd_ready, ser_out, ser_valid, done, busy;
   logic         sr_shift_left, sr_shift_right;
   logic [W-1:0] rx_data, sr_data_in;
   logic [1:0]   sr_mode;
   logic [W-1:0] reg_q;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   shift_reg_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .abort(abort), .ser_in(ser_in),
      .ser_out(ser_out), .ser_valid(ser_valid), .rx_data(rx_data), .done(done),
      .busy(busy), .sr_mode(sr_mode), .sr_data_in(sr_data_in),
      .sr_shift_left(sr_shift_left), .sr_shift_right(sr_shift_right),
      .sr_data_out(reg_q)
   );

   // External universal shift register driven by the sequencer.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) reg_q <= '0;
      else begin
         case (sr_mode)
            2'b01: reg_q <= {reg_q[W-2:0], sr_shift_left};
            2'b10: reg_q <= {sr_shift_right, reg_q[W-1:1]};
            2'b11: reg_q <= sr_data_in;
            default: reg_q <= reg_q;
         endcase
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Transfer model: phase = cycles since acceptance (0 idle, 1 load,
   // 2..W+1 bit slots, W+2 completion); received bits assembled by position.
   int           m_phase = 0;
   logic [1:0]   m_op = 2'b00;
   logic [W-1:0] m_data = '0, m_acc = '0, m_rx = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= 0; m_op <= 2'b00; m_data <= '0; m_acc <= '0; m_rx <= '0;
      end else if (m_phase == 0) begin
         if (cmd_valid) begin
            m_phase <= 1; m_op <= cmd_op; m_data <= cmd_data; m_acc <= '0;
         end
      end else if (m_phase == W + 2) begin
         if (m_op[1]) m_rx <= m_acc;
         m_phase <= 0;
      end else if (abort) begin
         m_phase <= 0;
      end else begin
         if (m_phase >= 2 && m_op[1]) begin
            if (m_op[0]) m_acc[m_phase-2] <= ser_in;
            else         m_acc[W-1-(m_phase-2)] <= ser_in;
         end
         m_phase <= m_phase + 1;
      end
   end

   always @(negedge clk) begin
      logic         sh;
      int           i;
      logic [1:0]   e_mode;
      logic         e_out, e_left, e_right, e_done;
      logic [W-1:0] e_din, e_rx;
      sh      = (m_phase >= 2) && (m_phase <= W + 1);
      i       = sh ? m_phase - 2 : 0;
      e_mode  = (m_phase == 1) ? 2'b11 : sh ? (m_op[0] ? 2'b10 : 2'b01) : 2'b00;
      e_out   = (sh && !m_op[1]) ? (m_op[0] ? m_data[i] : m_data[W-1-i]) : 1'b0;
      e_left  = (sh && m_op == 2'b10) ? ser_in : 1'b0;
      e_right = (sh && m_op == 2'b11) ? ser_in : 1'b0;
      e_done  = (m_phase == W + 2);
      e_din   = (m_phase == 1 && !m_op[1]) ? m_data : '0;
      e_rx    = (e_done && m_op[1]) ? m_acc : m_rx;
      check("cmd_ready", 32'(cmd_ready), 32'(m_phase == 0 && rst_n));
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("sr_mode", 32'(sr_mode), 32'(e_mode));
      check("sr_data_in", 32'(sr_data_in), 32'(e_din));
      check("ser_valid", 32'(ser_valid), 32'(sh));
      check("ser_out", 32'(ser_out), 32'(e_out));
      check("sr_shift_left", 32'(sr_shift_left), 32'(e_left));
      check("sr_shift_right", 32'(sr_shift_right), 32'(e_right));
      check("done", 32'(done), 32'(e_done));
      check("rx_data", 32'(rx_data), 32'(e_rx));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!cmd_ready && n < 20) begin
         tick();
         n++;
      end
      check("ready_wait", 32'(cmd_ready), 32'd1);
   endtask

   // Issues one command and records six cycles (load, W shifts, done).
   task automatic run_cmd(input logic [1:0] op, input logic [3:0] data, input logic [3:0] bits,
                          output logic [11:0] modes, output logic [3:0] outs,
                          output logic [5:0] vals, output logic [5:0] dns, output logic [3:0] rxd);
      wait_ready();
      cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
      tick();
      cmd_valid = 1'b0;
      modes = '0; outs = '0; vals = '0; dns = '0; rxd = '0;
      for (int k = 0; k < 6; k++) begin
         ser_in = (k >= 1 && k <= 4) ? bits[4-k] : 1'b0;
         @(negedge clk);
         modes[2*(5-k) +: 2] = sr_mode;
         if (k >= 1 && k <= 4) outs[4-k] = ser_out;
         vals[5-k] = ser_valid;
         dns[5-k]  = done;
         if (k == 5) rxd = rx_data;
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] modes;
      logic [3:0]  outs, rxd;
      logic [5:0]  vals, dns;

      #1 rst_n = 1'b0;
      #2;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(cmd_ready), 32'd0);
      check("rst_mode", 32'(sr_mode), 32'd0);
      check("rst_rx", 32'(rx_data), 32'd0);
      check("rst_ser_valid", 32'(ser_valid), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      run_cmd(2'b00, 4'b1011, 4'b0000, modes, outs, vals, dns, rxd);
      check("txmsb_modes", 32'(modes), 32'h0D54);
      check("txmsb_bits", 32'(outs), 32'b1011);
      check("txmsb_valid", 32'(vals), 32'b011110);
      check("txmsb_done", 32'(dns), 32'b000001);

      run_cmd(2'b01, 4'b1011, 4'b0000, modes, outs, vals, dns, rxd);
      check("txlsb_modes", 32'(modes), 32'h0EA8);
      check("txlsb_bits", 32'(outs), 32'b1101);

      run_cmd(2'b10, 4'b0000, 4'b1100, modes, outs, vals, dns, rxd);
      check("rxmsb_word", 32'(rxd), 32'b1100);
      check("rxmsb_dns", 32'(dns), 32'b000001);
      @(negedge clk);
      check("rxmsb_held", 32'(rx_data), 32'b1100);
      tick();

      run_cmd(2'b11, 4'b0000, 4'b1100, modes, outs, vals, dns, rxd);
      check("rxlsb_word", 32'(rxd), 32'b0011);
      check("rxlsb_bits_out", 32'(outs), 32'b0000);
      @(negedge clk);
      check("rxlsb_held", 32'(rx_data), 32'b0011);
      tick();

      // Abort in the second shift slot of an RX, with a command pulsed while busy.
      wait_ready();
      cmd_valid = 1'b1; cmd_op = 2'b10; cmd_data = 4'b1111; ser_in = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      cmd_valid = 1'b1; cmd_op = 2'b00;
      @(negedge clk);
      check("abort_busy_ready", 32'(cmd_ready), 32'd0);
      tick();
      cmd_valid = 1'b0; abort = 1'b1;
      tick();
      abort = 1'b0;
      @(negedge clk);
      check("abort_idle", 32'(busy), 32'd0);
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_rx_kept", 32'(rx_data), 32'b0011);
      tick();
      @(negedge clk);
      check("busy_cmd_dropped", 32'(busy), 32'd0);
      tick();

      // Reset in the third shift slot of a TX.
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 4'b1011;
      tick();
      cmd_valid = 1'b0;
      tick(); tick(); tick();
      rst_n = 1'b0;
      #1;
      check("midrst_mode", 32'(sr_mode), 32'd0);
      check("midrst_valid", 32'(ser_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_ser_out", 32'(ser_out), 32'd0);
      check("midrst_ready", 32'(cmd_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      #1;
      check("postrst_ready", 32'(cmd_ready), 32'd1);
      tick();
      run_cmd(2'b00, 4'b1011, 4'b0000, modes, outs, vals, dns, rxd);
      check("postrst_bits", 32'(outs), 32'b1011);
      check("postrst_done", 32'(dns), 32'b000001);

      for (int c = 0; c < 600; c++) begin
         rst_n     = ($urandom_range(0, 63) != 0);
         cmd_valid = ($urandom_range(0, 2) != 0);
         cmd_op    = 2'($urandom_range(0, 3));
         cmd_data  = 4'($urandom_range(0, 15));
         ser_in    = 1'($urandom_range(0, 1));
         abort     = ($urandom_range(0, 15) == 0);
         tick();
      end
      rst_n = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
      repeat (10) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
